// File: rtl/ir_ctrl_pkg.sv
// Shared types and constants for the IR command intake path.
package ir_ctrl_pkg;

   // Intake FSM states
   typedef enum logic {
      IDLE  = 1'b0,
      CHECK = 1'b1
   } intake_state_t;

   // NEC frame field offsets (LSB-first packing) and field width
   localparam int unsigned ADDR_LSB  = 0;
   localparam int unsigned NADDR_LSB = 8;
   localparam int unsigned CMD_LSB   = 16;
   localparam int unsigned NCMD_LSB  = 24;
   localparam int unsigned FIELD_W   = 8;

   // Queue entry layout: {repeat, cmd[7:0]}
   typedef struct packed {
      logic                rpt;
      logic [FIELD_W-1:0]  cmd;
   } fifo_entry_t;

   localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/ir_cmd_scheduler_if.sv
// Receiver-side frame intake and application-side command handshake.
interface ir_cmd_scheduler_if;
   logic [31:0] Frame_Data;
   logic        Frame_Valid;
   logic        Cmd_Ready;
   logic        Clear;
   logic        Cmd_Valid;
   logic [7:0]  Cmd;
   logic        Cmd_Repeat;
   logic        Overflow;
   logic [7:0]  Drop_Count;

   modport master (
      output Frame_Data, Frame_Valid, Cmd_Ready, Clear,
      input  Cmd_Valid, Cmd, Cmd_Repeat, Overflow, Drop_Count
   );

   modport slave (
      input  Frame_Data, Frame_Valid, Cmd_Ready, Clear,
      output Cmd_Valid, Cmd, Cmd_Repeat, Overflow, Drop_Count
   );
endinterface

// File: rtl/ir_cmd_fifo.sv
// Small synchronous FIFO; a push into a full queue succeeds when a pop happens in the same cycle.
module ir_cmd_fifo #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WIDTH      = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_q];

   // Storage array; contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// NEC command intake: validates frames, tags key-hold repeats, queues commands, counts drops.
module ir_cmd_scheduler
   import ir_ctrl_pkg::*;
#(
   parameter logic [7:0]  ADDR       = 8'h00,
   parameter bit          ADDR_CHECK = 1'b1,
   parameter int unsigned REPEAT_WIN = 5_400_000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic              clk,
   input logic              Reset,
   ir_cmd_scheduler_if.slave bus
);

   localparam int unsigned TMR_W = $clog2(REPEAT_WIN + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(REPEAT_WIN);

   intake_state_t      state_q;
   intake_state_t      state_d;
   logic [31:0]        frame_q;
   logic [31:0]        frame_d;
   logic               chk_en;

   logic [TMR_W-1:0]   timer_q;
   logic [FIELD_W-1:0] last_cmd_q;
   logic               last_valid_q;
   logic               overflow_q;
   logic [7:0]         drop_cnt_q;

   logic [FIELD_W-1:0] cmd_w;
   logic               cmd_ok;
   logic               addr_ok;
   logic               frame_ok;
   logic               is_rpt;
   logic               pop;
   logic               push;
   logic               drop;
   logic               fifo_full;
   logic               fifo_empty;
   fifo_entry_t        wentry;
   fifo_entry_t        head_e;

   // Intake state and frame latch
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
      end
   end

   // Next-state: latch in IDLE, evaluate for exactly one cycle in CHECK
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      chk_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Frame_Valid) begin
               frame_d = bus.Frame_Data;
               state_d = CHECK;
            end
         end
         CHECK: begin
            chk_en  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame validation, repeat tagging and push/drop decision
   always_comb begin
      cmd_w    = frame_q[CMD_LSB +: FIELD_W];
      cmd_ok   = (frame_q[NCMD_LSB +: FIELD_W] == ~cmd_w);
      addr_ok  = !ADDR_CHECK ||
                 ((frame_q[ADDR_LSB +: FIELD_W] == ADDR) &&
                  (frame_q[NADDR_LSB +: FIELD_W] == ~ADDR));
      frame_ok = chk_en && cmd_ok && addr_ok;
      is_rpt   = last_valid_q && (cmd_w == last_cmd_q) && (timer_q < TMR_MAX);
      pop      = !fifo_empty && bus.Cmd_Ready;
      push     = frame_ok && (!fifo_full || pop);
      drop     = frame_ok && fifo_full && !pop;
      wentry.rpt = is_rpt;
      wentry.cmd = cmd_w;
   end

   // Repeat history: timer restarts on every valid frame, even a dropped one
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         timer_q      <= '0;
         last_cmd_q   <= '0;
         last_valid_q <= 1'b0;
      end else if (frame_ok) begin
         timer_q      <= '0;
         last_cmd_q   <= cmd_w;
         last_valid_q <= 1'b1;
      end else if (timer_q != TMR_MAX) begin
         timer_q <= timer_q + TMR_W'(1);
      end
   end

   // Sticky overflow flag and saturating drop counter; Clear takes priority
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (bus.Clear) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   ir_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (Reset),
      .push  (push),
      .pop   (pop),
      .wdata (wentry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head_e)
   );

   // Head is masked while empty so stale storage never reaches the consumer
   assign bus.Cmd_Valid  = !fifo_empty;
   assign bus.Cmd        = fifo_empty ? '0 : head_e.cmd;
   assign bus.Cmd_Repeat = !fifo_empty && head_e.rpt;
   assign bus.Overflow   = overflow_q;
   assign bus.Drop_Count = drop_cnt_q;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed bench for ir_cmd_scheduler: vector table plus multi-cycle sequences.
module tb_ir_cmd_scheduler;

   typedef struct packed {
      logic [31:0] frame;
      logic        push;
      logic [7:0]  cmd;
      logic        rpt;
   } vec_t;

   localparam int unsigned NVEC = 10;

   logic clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   ir_cmd_scheduler_if bus ();

   ir_cmd_scheduler #(
      .ADDR       (8'h00),
      .ADDR_CHECK (1'b1),
      .REPEAT_WIN (2000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   function automatic logic [31:0] mk(input logic [7:0] c);
      return {~c, c, 8'hFF, 8'h00};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drives a one-cycle Frame_Valid strobe; returns at the negedge inside CHECK
   task automatic send_frame(input logic [31:0] data);
      bus.Frame_Data  = data;
      bus.Frame_Valid = 1'b1;
      @(negedge clk);
      bus.Frame_Valid = 1'b0;
   endtask

   // Single frame into an empty queue, checked at N+1 and N+2, then popped
   task automatic send_check(input string name, input vec_t v);
      send_frame(v.frame);
      check({name, "_lat"}, 32'(bus.Cmd_Valid), 32'(0));
      @(negedge clk);
      check({name, "_valid"}, 32'(bus.Cmd_Valid), 32'(v.push));
      if (v.push) begin
         check({name, "_cmd"}, 32'(bus.Cmd), 32'(v.cmd));
         check({name, "_rpt"}, 32'(bus.Cmd_Repeat), 32'(v.rpt));
         bus.Cmd_Ready = 1'b1;
         @(negedge clk);
         bus.Cmd_Ready = 1'b0;
         check({name, "_empty"}, 32'(bus.Cmd_Valid), 32'(0));
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exp_q [4];
      vec_t       v;

      vecs[0] = '{frame: 32'hBE40_FF00, push: 1'b0, cmd: 8'h00, rpt: 1'b0};
      vecs[1] = '{frame: 32'hBF40_FE01, push: 1'b0, cmd: 8'h00, rpt: 1'b0};
      vecs[2] = '{frame: 32'hBF40_FF00, push: 1'b1, cmd: 8'h40, rpt: 1'b0};
      vecs[3] = '{frame: 32'hBF40_FF00, push: 1'b1, cmd: 8'h40, rpt: 1'b1};
      vecs[4] = '{frame: 32'hBF40_FE00, push: 1'b0, cmd: 8'h00, rpt: 1'b0};
      vecs[5] = '{frame: 32'hBF40_FF00, push: 1'b1, cmd: 8'h40, rpt: 1'b1};
      vecs[6] = '{frame: 32'hEF10_FF00, push: 1'b1, cmd: 8'h10, rpt: 1'b0};
      vecs[7] = '{frame: 32'hBF40_FF00, push: 1'b1, cmd: 8'h40, rpt: 1'b0};
      vecs[8] = '{frame: 32'h00FF_FF00, push: 1'b1, cmd: 8'hFF, rpt: 1'b0};
      vecs[9] = '{frame: 32'hBF40_00FF, push: 1'b0, cmd: 8'h00, rpt: 1'b0};

      Reset           = 1'b0;
      bus.Frame_Data  = '0;
      bus.Frame_Valid = 1'b0;
      bus.Cmd_Ready   = 1'b0;
      bus.Clear       = 1'b0;
      repeat (3) @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);

      check("rst_valid", 32'(bus.Cmd_Valid), 32'(0));
      check("rst_cmd",   32'(bus.Cmd), 32'(0));
      check("rst_rpt",   32'(bus.Cmd_Repeat), 32'(0));
      check("rst_ovf",   32'(bus.Overflow), 32'(0));
      check("rst_drop",  32'(bus.Drop_Count), 32'(0));

      // Table: validation and repeat tagging, frames a few cycles apart
      for (int i = 0; i < int'(NVEC); i++) begin
         send_check($sformatf("vec%0d", i), vecs[i]);
         @(negedge clk);
      end

      // Repeat window: inside (1000 cycles) then outside (3000 cycles)
      v = '{frame: mk(8'h40), push: 1'b1, cmd: 8'h40, rpt: 1'b0};
      send_check("win_first", v);
      repeat (1000) @(negedge clk);
      v.rpt = 1'b1;
      send_check("win_inside", v);
      repeat (3000) @(negedge clk);
      v.rpt = 1'b0;
      send_check("win_outside", v);
      @(negedge clk);

      // Overflow: six frames with no consumer, depth four
      for (int c = 1; c <= 6; c++) begin
         send_frame(mk(8'(c)));
         @(negedge clk);
      end
      check("ovf_valid", 32'(bus.Cmd_Valid), 32'(1));
      check("ovf_flag",  32'(bus.Overflow), 32'(1));
      check("ovf_count", 32'(bus.Drop_Count), 32'(2));
      bus.Clear = 1'b1;
      @(negedge clk);
      bus.Clear = 1'b0;
      check("clr_flag",  32'(bus.Overflow), 32'(0));
      check("clr_count", 32'(bus.Drop_Count), 32'(0));

      // Full queue with a pop during CHECK: frame accepted, nothing dropped
      send_frame(mk(8'h07));
      bus.Cmd_Ready = 1'b1;
      @(negedge clk);
      bus.Cmd_Ready = 1'b0;
      check("fullpop_count", 32'(bus.Drop_Count), 32'(0));
      check("fullpop_flag",  32'(bus.Overflow), 32'(0));

      // Clear coinciding with a drop wins
      send_frame(mk(8'h08));
      bus.Clear = 1'b1;
      @(negedge clk);
      bus.Clear = 1'b0;
      check("clrwin_flag",  32'(bus.Overflow), 32'(0));
      check("clrwin_count", 32'(bus.Drop_Count), 32'(0));
      send_frame(mk(8'h09));
      @(negedge clk);
      check("drop9_flag",  32'(bus.Overflow), 32'(1));
      check("drop9_count", 32'(bus.Drop_Count), 32'(1));

      // Drain at one entry per cycle: exactly 2,3,4,7 in order
      exp_q[0] = 8'h02;
      exp_q[1] = 8'h03;
      exp_q[2] = 8'h04;
      exp_q[3] = 8'h07;
      bus.Cmd_Ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain%0d_valid", i), 32'(bus.Cmd_Valid), 32'(1));
         check($sformatf("drain%0d_cmd", i),   32'(bus.Cmd), 32'(exp_q[i]));
         check($sformatf("drain%0d_rpt", i),   32'(bus.Cmd_Repeat), 32'(0));
         @(negedge clk);
      end
      bus.Cmd_Ready = 1'b0;
      check("drain_empty", 32'(bus.Cmd_Valid), 32'(0));

      // Reset during CHECK with three entries queued
      for (int i = 0; i < 3; i++) begin
         send_frame(mk(8'h20));
         @(negedge clk);
      end
      check("pre_rst_valid", 32'(bus.Cmd_Valid), 32'(1));
      check("pre_rst_cmd",   32'(bus.Cmd), 32'(8'h20));
      send_frame(mk(8'h20));
      Reset = 1'b0;
      #1;
      check("midrst_valid", 32'(bus.Cmd_Valid), 32'(0));
      check("midrst_cmd",   32'(bus.Cmd), 32'(0));
      check("midrst_rpt",   32'(bus.Cmd_Repeat), 32'(0));
      check("midrst_ovf",   32'(bus.Overflow), 32'(0));
      check("midrst_drop",  32'(bus.Drop_Count), 32'(0));
      @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      v = '{frame: mk(8'h20), push: 1'b1, cmd: 8'h20, rpt: 1'b0};
      send_check("post_rst", v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ir_cmd_scheduler.md
# ir_cmd_scheduler

Command-intake controller placed directly behind the NEC infrared receiver. It accepts each decoded 32-bit frame, validates address and command fields, and tags key-hold repeats. Accepted commands are queued in a small FIFO and handed to the application over a valid/ready handshake. Drops caused by a full queue are counted and flagged, so the receiver never needs backpressure.

## Interface
Parameters:
- ADDR, 8'h00: expected NEC address byte.
- ADDR_CHECK, 1: 1 = reject frames whose address ≠ ADDR; 0 = accept any address.
- REPEAT_WIN, 5_400_000: repeat window in clk cycles (≈108 ms at 50 MHz).
- FIFO_DEPTH, 4: command queue depth; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Frame_Data  in  32  decoded frame, LSB-first packing: [7:0] address, [15:8] ~address, [23:16] command, [31:24] ~command.
- Frame_Valid  in  1  one-cycle strobe; Frame_Data is valid in that cycle.
- Cmd_Ready  in  1  consumer accepts the head entry.
- Clear  in  1  synchronous clear of Overflow and Drop_Count.
- Cmd_Valid  out  1  FIFO non-empty; reset 0.
- Cmd  out  8  command byte of head entry; reset 0.
- Cmd_Repeat  out  1  head entry is a repeat; reset 0.
- Overflow  out  1  sticky; a frame was dropped on full FIFO; reset 0.
- Drop_Count  out  8  saturating count of drops; reset 0.

## Operation
- Intake FSM with two states.
  - IDLE: when Frame_Valid = 1, latch Frame_Data and go to CHECK.
  - CHECK: evaluate the latched frame for one cycle, then return to IDLE unconditionally.
  - Frame_Valid asserted while in CHECK is ignored; it is neither counted nor queued.
- A frame is valid only if both hold:
  - [31:24] == ~[23:16].
  - When ADDR_CHECK = 1: [7:0] == ADDR and [15:8] == ~ADDR.
- An invalid frame is discarded silently. It does not change the repeat state.
- Repeat tag for a valid frame: Cmd_Repeat = 1 when all of the following hold:
  - last_valid = 1;
  - command == last_cmd;
  - the repeat timer is < REPEAT_WIN.
- Repeat timer behaviour:
  - Clears to 0 on every valid frame, whether or not it was pushed.
  - Otherwise increments, saturating at REPEAT_WIN.
  - last_cmd and last_valid update on every valid frame.
- Push rules for a valid frame:
  - Pushed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise dropped: Overflow ← 1 and Drop_Count increments, saturating at 255.
- Pop occurs when Cmd_Valid && Cmd_Ready. Cmd and Cmd_Repeat show the head entry combinationally from the FIFO read pointer.
- Clear and a drop in the same cycle: Clear wins, giving Overflow = 0 and Drop_Count = 0.
- Push into an empty FIFO together with Cmd_Ready = 1: the entry is not bypassed. It becomes the head on the next cycle.
- Reset asserted mid-frame or mid-CHECK:
  - FSM returns to IDLE, FIFO is emptied, last_valid = 0, timer = 0.
  - All outputs take their reset values immediately.

## Timing
- Frame_Valid in cycle N → CHECK in N+1 → entry visible with Cmd_Valid = 1 in N+2 (FIFO previously empty).
- Minimum spacing for back-to-back Frame_Valid: 2 cycles.
- Pop throughput: one entry per cycle.
- Cmd_Valid falls in the cycle after the last entry is popped.
- Overflow and Drop_Count update at the end of the CHECK cycle.

## Structure
- Package ir_ctrl_pkg:
  - intake state enum (IDLE, CHECK);
  - NEC field offset constants (ADDR_LSB = 0, NADDR_LSB = 8, CMD_LSB = 16, NCMD_LSB = 24);
  - 9-bit FIFO entry layout {repeat, cmd[7:0]}.
- Sub-module ir_cmd_fifo:
  - synchronous FIFO with parameters FIFO_DEPTH and width 9;
  - push, pop, full, empty and head-data outputs;
  - same asynchronous active-low reset.
- Top level holds the FSM, validation, repeat timer, and drop logic.

## Test plan
- Single frame Frame_Data = 32'hBF40_FF00 (cmd 0x40, ADDR 0x00) → Cmd_Valid = 1 in cycle N+2; Cmd = 0x40, Cmd_Repeat = 0; one pop empties the FIFO.
- Same frame sent twice, 1000 cycles apart, with REPEAT_WIN = 2000 → second entry has Cmd_Repeat = 1. Sent again 3000 cycles later → Cmd_Repeat = 0.
- Corrupted frame 32'hBE40_FF00, then address 0x01 with ADDR_CHECK = 1 → no push. Following valid 0x40 frame within the window → Cmd_Repeat = 0 (last_valid still 0).
- Cmd_Ready = 0; six valid frames with FIFO_DEPTH = 4 → four queued in order, Overflow = 1, Drop_Count = 2. Clear → both 0.
- FIFO full and Cmd_Ready = 1 during CHECK → new frame accepted, Drop_Count unchanged, entry count stays 4.
- Reset pulse while in CHECK with 3 entries queued → Cmd_Valid = 0 and Cmd = 0. Next frame is tagged non-repeat.
